vx_perf_pipeline_ctrl: RTL and testbench
========================================

VX_PERF_PIPELINE_CTRL -- requirements
Module: VX_perf_pipeline_ctrl

Interface
REQ-001 SHALL have parameter CTR_W, default `PERF_CTR_BITS (44), the width of every counter.
REQ-002 SHALL have parameter NUM_CTRS, default 10, the number of counters; the value is fixed and not user-overridable.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port evt, input, NUM_CTRS bits: one-cycle event pulses, one bit per counter.
- Bit order: 0 loads, 1 stores, 2 branches, 3 ibf_stall, 4 scb_stall, 5 lsu_stall, 6 csr_stall, 7 alu_stall, 8 fpu_stall, 9 gpu_stall.
REQ-006 SHALL have port count_en, input, 1 bit: global count enable; when low, counters hold.
REQ-007 SHALL have port clear, input, 1 bit: request to zero all live counters.
REQ-008 SHALL have port dump_req, input, 1 bit: request to snapshot the counters and stream them out.
REQ-009 SHALL have port dump_busy, output, 1 bit: high while a dump is in progress.
REQ-010 SHALL have port dump_valid, output, 1 bit: stream word valid.
REQ-011 SHALL have port dump_ready, input, 1 bit: stream word accepted by the consumer.
REQ-012 SHALL have port dump_idx, output, 4 bits: index of the counter on dump_data.
REQ-013 SHALL have port dump_data, output, CTR_W bits: snapshot value of counter dump_idx.
REQ-014 SHALL have port dump_last, output, 1 bit: high on the word for index NUM_CTRS-1.
REQ-015 SHALL have port ctr_out, output, NUM_CTRS*CTR_W bits: live counter values, counter i in bits [i*CTR_W +: CTR_W].
- These values drive the perf pipeline interface slave fields.

Function
REQ-016 SHALL increment counter i by 1 in the cycle after evt[i]=1 while count_en=1; the counter is visible on ctr_out with 1-cycle latency.
REQ-017 SHALL wrap a counter from 2^CTR_W-1 to 0 on increment, with no saturation and no flag.
REQ-018 SHALL zero all live counters in the cycle after clear=1.
- A simultaneous evt is dropped; clear wins.
REQ-019 SHALL have clear act on live counters only; the snapshot and any dump in progress are not disturbed.
REQ-020 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-021 In IDLE, dump_req=1 SHALL copy all live counters into snapshot registers.
- The copy uses the pre-increment value of that cycle; an event in the same cycle is counted live but is not in the snapshot.
- The FSM enters STREAM with idx=0.
REQ-022 In STREAM, dump_valid SHALL be 1 and dump_busy SHALL be 1; dump_data equals snapshot[idx].
REQ-023 Handshake: a word transfers on dump_valid & dump_ready.
- idx increments on each transfer.
- The transfer with idx=NUM_CTRS-1 returns the FSM to IDLE, so dump_valid=0 in the next cycle.
REQ-024 While dump_valid=1 and dump_ready=0, dump_idx, dump_data and dump_last SHALL hold stable.
REQ-025 dump_req SHALL be ignored while in STREAM; there is no queueing.
REQ-026 dump_req in the cycle the last word transfers SHALL be ignored.
- A new dump starts only on a dump_req seen in IDLE.
REQ-027 Live counting SHALL continue unaffected during STREAM.
REQ-028 dump_last SHALL equal dump_valid & (idx==NUM_CTRS-1).

Reset
REQ-029 On reset=1, all live counters and snapshot registers SHALL be 0, the FSM SHALL be IDLE, idx SHALL be 0, and dump_valid, dump_busy and dump_last SHALL be 0.
REQ-030 Reset mid-STREAM SHALL abort the dump immediately.
- dump_valid=0 from the next cycle; no further words are sent.
REQ-031 reset SHALL take priority over clear, dump_req and evt.

Structure
REQ-032 Package VX_perf_pkg SHALL hold:
- the counter index constants (PERF_IDX_LOADS ... PERF_IDX_GPU_STALL);
- NUM_CTRS;
- the FSM state typedef (IDLE, STREAM).
REQ-033 Each counter SHALL be an instance of sub-module VX_perf_ctr, which has ports clk, reset, clear, inc, and a CTR_W-bit value output.
REQ-034 SHALL contain no combinational path from dump_ready to dump_valid or dump_data.

Verification
REQ-035 Counting and enable:
- Stimulus: evt[0] pulsed 5 cycles with count_en=1, then 3 cycles with count_en=0.
- Response: loads counter = 5; other counters = 0.
REQ-036 Wrap:
- Stimulus: preload by counting, or set CTR_W=4 and pulse evt[3] 17 times.
- Response: ibf_stall counter = 1.
REQ-037 Clear vs event:
- Stimulus: counters at 7; clear=1 and evt[1]=1 in the same cycle.
- Response: stores counter = 0 the next cycle.
REQ-038 Dump with backpressure:
- Stimulus: counters 0..9 hold values 10..19; dump_req=1; dump_ready toggles 1,0,1,...
- Response: 10 words with idx 0..9 and data 10..19, stable while stalled, dump_last only on idx 9, then dump_busy=0.
REQ-039 Live counting during dump:
- Stimulus: evt[9] pulsed every cycle during the dump.
- Response: streamed gpu_stall word equals the snapshot value; the live counter keeps increasing.
- Stimulus: a second dump_req mid-stream.
- Response: the request is ignored.
REQ-040 Reset mid-dump:
- Stimulus: reset=1 after word 3 transfers.
- Response: dump_valid=0 next cycle, all ctr_out = 0; a subsequent dump_req streams all zeros.

Source files
------------

// File: rtl/vx_perf_pipeline_ctrl_pkg.sv
// Shared constants and types for the perf counter block: counter indices, counter count, dump FSM states.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package VX_perf_pkg;

  localparam int NUM_CTRS = 10;

  localparam int PERF_IDX_LOADS     = 0;
  localparam int PERF_IDX_STORES    = 1;
  localparam int PERF_IDX_BRANCHES  = 2;
  localparam int PERF_IDX_IBF_STALL = 3;
  localparam int PERF_IDX_SCB_STALL = 4;
  localparam int PERF_IDX_LSU_STALL = 5;
  localparam int PERF_IDX_CSR_STALL = 6;
  localparam int PERF_IDX_ALU_STALL = 7;
  localparam int PERF_IDX_FPU_STALL = 8;
  localparam int PERF_IDX_GPU_STALL = 9;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } dump_state_e;

endpackage

// File: rtl/vx_perf_pipeline_ctrl_ctr.sv
// Single wrapping event counter, value visible one cycle after inc; clear beats inc, reset beats both.
module VX_perf_ctr #(
  parameter int CTR_W = `PERF_CTR_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CTR_W-1:0] value
);

  logic [CTR_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= r_value + CTR_W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/vx_perf_pipeline_ctrl.sv
// Perf counters with snapshot-and-stream dump; counters update 1 cycle after evt.
// Dump words hold under dump_ready=0; dump_valid/dump_data come only from registers.
module vx_perf_pipeline_ctrl
  import VX_perf_pkg::*;
#(
  parameter  int CTR_W    = `PERF_CTR_BITS,
  localparam int NUM_CTRS = VX_perf_pkg::NUM_CTRS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CTRS-1:0]       evt,
  input  logic                      count_en,
  input  logic                      clear,
  input  logic                      dump_req,
  output logic                      dump_busy,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [3:0]                dump_idx,
  output logic [CTR_W-1:0]          dump_data,
  output logic                      dump_last,
  output logic [NUM_CTRS*CTR_W-1:0] ctr_out
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CTRS - 1);

  logic [CTR_W-1:0] w_ctr  [NUM_CTRS];
  logic [CTR_W-1:0] r_snap [NUM_CTRS];
  dump_state_e      r_state;
  dump_state_e      w_state_nxt;
  logic [3:0]       r_idx;
  logic             w_start;
  logic             w_xfer;
  logic             w_last_idx;

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
    VX_perf_ctr #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (evt[g] & count_en),
      .value (w_ctr[g])
    );
    assign ctr_out[g*CTR_W +: CTR_W] = w_ctr[g];
  end

  assign w_start    = (r_state == IDLE) & dump_req;
  assign w_xfer     = (r_state == STREAM) & dump_ready;
  assign w_last_idx = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (dump_req) w_state_nxt = STREAM;
      STREAM:  if (dump_ready && w_last_idx) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = (r_state == STREAM);
    dump_busy  = (r_state == STREAM);
    dump_last  = (r_state == STREAM) & w_last_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_start) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= w_last_idx ? 4'd0 : r_idx + 4'd1;
    end
  end

  // Snapshot takes the pre-increment live values, so a same-cycle event is counted live only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRS; i++) r_snap[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < NUM_CTRS; i++) r_snap[i] <= w_ctr[i];
    end
  end

  assign dump_idx  = r_idx;
  assign dump_data = r_snap[r_idx];

endmodule

// File: tb/tb_vx_perf_pipeline_ctrl.sv
// Directed and randomized checks of vx_perf_pipeline_ctrl against a cycle-level reference model.
module tb_vx_perf_pipeline_ctrl;
  import VX_perf_pkg::*;

  localparam int CTR_W = 8;
  localparam int N     = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       evt;
  logic               count_en;
  logic               clear;
  logic               dump_req;
  logic               dump_busy;
  logic               dump_valid;
  logic               dump_ready;
  logic [3:0]         dump_idx;
  logic [CTR_W-1:0]   dump_data;
  logic               dump_last;
  logic [N*CTR_W-1:0] ctr_out;

  always #5 clk = ~clk;

  vx_perf_pipeline_ctrl #(
    .CTR_W (CTR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt        (evt),
    .count_en   (count_en),
    .clear      (clear),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .ctr_out    (ctr_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: live counters, snapshot, and whether a dump is streaming at which word.
  logic [CTR_W-1:0] m_ctr  [N];
  logic [CTR_W-1:0] m_snap [N];
  bit               m_busy;
  int               m_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CTR_W-1:0] live(input int i);
    return ctr_out[i*CTR_W +: CTR_W];
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_ctr[i]  = '0;
        m_snap[i] = '0;
      end
      m_busy = 0;
      m_idx  = 0;
    end else begin
      if (m_busy) begin
        if (dump_ready) begin
          if (m_idx == N - 1) begin
            m_busy = 0;
            m_idx  = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (dump_req) begin
        for (int i = 0; i < N; i++) m_snap[i] = m_ctr[i];
        m_busy = 1;
        m_idx  = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (clear) m_ctr[i] = '0;
        else if (count_en && evt[i]) m_ctr[i] = m_ctr[i] + 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) check($sformatf("ctr%0d", i), live(i), m_ctr[i]);
    check("valid", dump_valid, m_busy);
    check("busy", dump_busy, m_busy);
    check("idx", dump_idx, m_idx);
    check("last", dump_last, (m_busy && m_idx == N - 1));
    if (m_busy) check("data", dump_data, m_snap[m_idx]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int words;
    int cyc;
    bit stalled;
    logic [3:0] p_idx;
    logic [CTR_W-1:0] p_data;

    reset = 1'b1; evt = '0; count_en = 1'b1; clear = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = '0;
      m_snap[i] = '0;
    end
    m_busy = 0;
    m_idx  = 0;

    step();
    step();
    check("rst_valid", dump_valid, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_ctrs", |ctr_out, 0);
    reset = 1'b0;

    // Counting with enable
    evt = 10'b1;
    repeat (5) step();
    count_en = 1'b0;
    repeat (3) step();
    evt = '0;
    count_en = 1'b1;
    step();
    check("loads_5", live(PERF_IDX_LOADS), 5);
    for (int i = 1; i < N; i++) check("others_0", live(i), 0);

    // Wrap at 2^CTR_W
    do_reset();
    evt = 10'b1000;
    repeat (257) step();
    evt = '0;
    step();
    check("wrap_ibf", live(PERF_IDX_IBF_STALL), 1);

    // Clear beats a same-cycle event
    do_reset();
    evt = '1;
    repeat (7) step();
    check("pre_clear_7", live(PERF_IDX_STORES), 7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    evt = '0;
    check("clear_wins", live(PERF_IDX_STORES), 0);

    // Dump with alternating backpressure, live gpu_stall counting, ignored re-requests
    do_reset();
    for (int c = 0; c < 19; c++) begin
      for (int i = 0; i < N; i++) evt[i] = (c < 10 + i);
      step();
    end
    evt = '0;
    step();
    dump_req = 1'b1;
    evt[PERF_IDX_GPU_STALL] = 1'b1;
    step();
    dump_req = 1'b0;
    words = 0;
    cyc = 0;
    stalled = 0;
    p_idx = '0;
    p_data = '0;
    while (dump_busy && cyc < 100) begin
      dump_ready = (cyc % 2 == 0);
      dump_req = (cyc == 5 || cyc == 18);
      if (stalled) begin
        check("hold_idx", dump_idx, p_idx);
        check("hold_data", dump_data, p_data);
      end
      if (dump_valid && dump_ready) begin
        check("w_idx", dump_idx, words);
        check("w_data", dump_data, 10 + words);
        check("w_last", dump_last, (words == N - 1));
        words++;
      end
      stalled = dump_valid && !dump_ready;
      p_idx = dump_idx;
      p_data = dump_data;
      step();
      cyc++;
    end
    dump_req = 1'b0;
    dump_ready = 1'b0;
    evt = '0;
    check("dump_words", words, 10);
    check("dump_done_busy", dump_busy, 0);
    check("gpu_live_grew", (live(PERF_IDX_GPU_STALL) > 8'd19), 1);
    step();
    check("stays_idle", dump_valid, 0);

    // Reset in the middle of a dump
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    words = 0;
    cyc = 0;
    while (words < 4 && cyc < 50) begin
      if (dump_valid && dump_ready) words++;
      step();
      cyc++;
    end
    check("pre_abort_words", words, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", dump_valid, 0);
    check("abort_ctrs", |ctr_out, 0);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    words = 0;
    cyc = 0;
    while (dump_busy && cyc < 50) begin
      if (dump_valid) begin
        check("zero_data", dump_data, 0);
        if (dump_ready) words++;
      end
      step();
      cyc++;
    end
    check("zero_words", words, 10);

    // Randomized traffic against the model
    repeat (3000) begin
      reset      = ($urandom_range(0, 499) == 0);
      evt        = N'($urandom);
      count_en   = ($urandom_range(0, 7) != 0);
      clear      = ($urandom_range(0, 31) == 0);
      dump_req   = ($urandom_range(0, 15) == 0);
      dump_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
